spi_burst_ctrl: RTL and testbench

SPI_BURST_CTRL -- requirements
Module: spi_burst_ctrl

---
 rtl/spi_burst_ctrl_if.sv | 38 +++
 rtl/spi_burst_ctrl.sv | 111 +++++++++++
 tb/tb_spi_burst_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_burst_ctrl_if.sv
// Handshake bundle for the SPI burst controller:
// command, tx/rx byte streams and the byte-engine link.
interface spi_burst_ctrl_if;
  logic       cmd_valid;
  logic [3:0] cmd_len;
  logic       cmd_ready;
  logic       abort;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       done;
  logic       cs_n;
  logic       spi_start;
  logic [7:0] spi_data_in;
  logic       spi_busy;
  logic       spi_new_data;
  logic [7:0] spi_data_out;

  modport master (
    output cmd_valid, cmd_len, abort,
    output tx_data, tx_valid,
    output spi_busy, spi_new_data, spi_data_out,
    input  cmd_ready, tx_ready,
    input  rx_data, rx_valid, done,
    input  cs_n, spi_start, spi_data_in
  );

  modport slave (
    input  cmd_valid, cmd_len, abort,
    input  tx_data, tx_valid,
    input  spi_busy, spi_new_data, spi_data_out,
    output cmd_ready, tx_ready,
    output rx_data, rx_valid, done,
    output cs_n, spi_start, spi_data_in
  );
endinterface

// File: rtl/spi_burst_ctrl.sv
// SPI burst controller: frames 1..16 byte bursts with
// chip-select setup/hold/gap timing around a byte engine.
module spi_burst_ctrl #(
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 2
) (
  input logic       clk,
  input logic       rst,
  spi_burst_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SETUP, LOAD, XFER, HOLD, GAP
  } state_t;

  state_t     state;
  logic [3:0] rem;
  logic [7:0] cnt;
  logic       abort_q;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.tx_ready  = (state == LOAD) &&
                         !bus.spi_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      rem             <= '0;
      cnt             <= '0;
      abort_q         <= 1'b0;
      bus.cs_n        <= 1'b1;
      bus.spi_start   <= 1'b0;
      bus.spi_data_in <= '0;
      bus.rx_data     <= '0;
      bus.rx_valid    <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      bus.spi_start <= 1'b0;
      bus.rx_valid  <= 1'b0;
      bus.done      <= 1'b0;
      unique case (state)
        IDLE: begin
          abort_q <= 1'b0;
          if (bus.cmd_valid) begin
            rem      <= bus.cmd_len;
            bus.cs_n <= 1'b0;
            cnt      <= 8'(CS_SETUP);
            state    <= (CS_SETUP > 1) ? SETUP : LOAD;
          end
        end
        // Leaves one cycle early: the LOAD handshake
        // cycle completes the setup window.
        SETUP: begin
          if (bus.abort) begin
            cnt   <= 8'(CS_HOLD);
            state <= HOLD;
          end else if (cnt <= 8'd2) begin
            state <= LOAD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        LOAD: begin
          if (bus.abort) begin
            cnt   <= 8'(CS_HOLD);
            state <= HOLD;
          end else if (bus.tx_valid && !bus.spi_busy) begin
            bus.spi_data_in <= bus.tx_data;
            bus.spi_start   <= 1'b1;
            state           <= XFER;
          end
        end
        XFER: begin
          if (bus.abort)
            abort_q <= 1'b1;
          if (bus.spi_new_data) begin
            bus.rx_data  <= bus.spi_data_out;
            bus.rx_valid <= 1'b1;
            if (rem == 4'd0 || abort_q || bus.abort) begin
              abort_q <= 1'b0;
              cnt     <= 8'(CS_HOLD);
              state   <= HOLD;
            end else begin
              rem   <= rem - 4'd1;
              state <= LOAD;
            end
          end
        end
        HOLD: begin
          if (cnt <= 8'd1) begin
            bus.cs_n <= 1'b1;
            bus.done <= 1'b1;
            cnt      <= 8'(CS_GAP);
            state    <= GAP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          if (cnt <= 8'd1)
            state <= IDLE;
          else
            cnt <= cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Scoreboard bench for spi_burst_ctrl with an
// echoing byte-engine model (rx = tx ^ 0x99).
module tb_spi_burst_ctrl;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int CS_GAP   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  spi_burst_ctrl_if bus();

  spi_burst_ctrl #(
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int exp_done = 0;
  int n_start = 0, n_rx = 0, n_done = 0;
  int n_fall = 0, n_rise = 0;
  int setup_meas = -1, hold_meas = -1;
  int gap_meas = -1;
  int lo_ctr = 0, hi_ctr = 0, tail_ctr = 0;
  bit first_seen = 1'b0;
  logic prev_cs = 1'b1;
  int busy_cnt = 0;
  logic [7:0] cap = '0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [7:0] echo(input logic [7:0] d);
    return d ^ 8'h99;
  endfunction

  // byte engine: busy 3 cycles, then new_data strobe
  initial begin
    bus.spi_busy     = 1'b0;
    bus.spi_new_data = 1'b0;
    bus.spi_data_out = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.spi_new_data = 1'b0;
      if (!rst) begin
        busy_cnt     = 0;
        bus.spi_busy = 1'b0;
      end else begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            bus.spi_new_data = 1'b1;
            bus.spi_data_out = echo(cap);
            bus.spi_busy     = 1'b0;
          end
        end
        if (bus.spi_start) begin
          chk("start_while_busy", bus.spi_busy, 0);
          cap          = bus.spi_data_in;
          busy_cnt     = 3;
          bus.spi_busy = 1'b1;
        end
      end
    end
  end

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.rx_valid) begin
          n_rx++;
          tail_ctr = 0;
          chk("rx_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0)
            chk("rx_data", bus.rx_data, exp_q.pop_front());
        end
        if (bus.done) begin
          n_done++;
          chk("ready_in_gap", bus.cmd_ready, 0);
          chk("done_expected", int'(exp_done > 0), 1);
          if (exp_done > 0)
            exp_done--;
        end
        if (bus.spi_start) begin
          n_start++;
          chk("cs_at_start", bus.cs_n, 0);
        end
        if (!bus.cs_n) begin
          if (prev_cs) begin
            n_fall++;
            gap_meas   = hi_ctr;
            lo_ctr     = 0;
            first_seen = 1'b0;
          end
          if (bus.spi_start && !first_seen) begin
            setup_meas = lo_ctr;
            first_seen = 1'b1;
          end
          lo_ctr++;
          tail_ctr++;
        end else begin
          if (!prev_cs) begin
            n_rise++;
            hold_meas = tail_ctr;
            hi_ctr    = 0;
          end
          hi_ctr++;
        end
      end
      prev_cs = bus.cs_n;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue_cmd(input logic [3:0] len,
                           input bit keep);
    int to = 0;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && to < 100) begin
      step();
      to++;
    end
    chk("cmd_accept", int'(to < 100), 1);
    exp_done++;
    step();
    if (!keep)
      bus.cmd_valid = 1'b0;
  endtask

  task automatic feed_byte(input logic [7:0] d,
                           input bit push);
    int to = 0;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && to < 200) begin
      step();
      to++;
    end
    chk("tx_accept", int'(to < 200), 1);
    if (push)
      exp_q.push_back(echo(d));
    step();
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int to = 0;
    while (n_done == prev && to < 300) begin
      step();
      to++;
    end
    chk("done_seen", int'(n_done > prev), 1);
  endtask

  task automatic wait_until_idle();
    int to = 0;
    while (!bus.cmd_ready && to < 100) begin
      step();
      to++;
    end
    chk("back_to_idle", bus.cmd_ready, 1);
  endtask

  initial begin
    int s0, r0, d0, f0, e0, to;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.abort     = 1'b0;
    bus.tx_data   = '0;
    bus.tx_valid  = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_cs_n", bus.cs_n, 1);
    chk("rst_spi_start", bus.spi_start, 0);
    chk("rst_spi_data_in", bus.spi_data_in, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_tx_ready", bus.tx_ready, 0);
    rst = 1'b1;
    step();
    chk("cmd_ready_after_rst", bus.cmd_ready, 1);

    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    step();
    chk("idle_abort_ready", bus.cmd_ready, 1);
    chk("idle_abort_cs", bus.cs_n, 1);

    // single byte
    s0 = n_start; r0 = n_rx; d0 = n_done;
    issue_cmd(4'd0, 1'b0);
    feed_byte(8'hA5, 1'b1);
    wait_done(d0);
    chk("t1_setup", setup_meas, CS_SETUP);
    chk("t1_hold", hold_meas, CS_HOLD);
    chk("t1_starts", n_start - s0, 1);
    chk("t1_rx", n_rx - r0, 1);
    wait_until_idle();

    // max burst
    s0 = n_start; r0 = n_rx; d0 = n_done; f0 = n_fall;
    e0 = n_rise;
    issue_cmd(4'd15, 1'b0);
    for (int i = 0; i < 16; i++)
      feed_byte(8'(i), 1'b1);
    wait_done(d0);
    chk("t2_starts", n_start - s0, 16);
    chk("t2_rx", n_rx - r0, 16);
    chk("t2_cs_falls", n_fall - f0, 1);
    chk("t2_cs_rises", n_rise - e0, 1);
    wait_until_idle();

    // stalled tx
    s0 = n_start; d0 = n_done;
    issue_cmd(4'd1, 1'b0);
    to = 0;
    while (!bus.tx_ready && to < 50) begin
      step();
      to++;
    end
    chk("t3_in_load", bus.tx_ready, 1);
    repeat (20) step();
    chk("t3_no_start", n_start - s0, 0);
    chk("t3_cs_low", bus.cs_n, 0);
    feed_byte(8'h3E, 1'b1);
    feed_byte(8'hC1, 1'b1);
    wait_done(d0);
    chk("t3_starts", n_start - s0, 2);
    wait_until_idle();

    // abort during byte 2 of 4
    s0 = n_start; r0 = n_rx; d0 = n_done;
    issue_cmd(4'd3, 1'b0);
    feed_byte(8'h10, 1'b1);
    feed_byte(8'h20, 1'b1);
    to = 0;
    while (!bus.spi_busy && to < 50) begin
      step();
      to++;
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    wait_done(d0);
    chk("t4_starts", n_start - s0, 2);
    chk("t4_rx", n_rx - r0, 2);
    wait_until_idle();

    // abort during SETUP
    s0 = n_start; r0 = n_rx; d0 = n_done;
    issue_cmd(4'd2, 1'b0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    wait_done(d0);
    chk("t5_starts", n_start - s0, 0);
    chk("t5_rx", n_rx - r0, 0);
    wait_until_idle();

    // back-to-back, cmd_valid held high
    f0 = n_fall; d0 = n_done;
    issue_cmd(4'd0, 1'b1);
    feed_byte(8'h11, 1'b1);
    wait_done(d0);
    exp_done++;
    d0 = n_done;
    to = 0;
    while (bus.cs_n && to < 50) begin
      step();
      to++;
    end
    feed_byte(8'h22, 1'b1);
    bus.cmd_valid = 1'b0;
    wait_done(d0);
    chk("t6_gap", gap_meas, CS_GAP + 1);
    repeat (20) step();
    chk("t6_bursts", n_fall - f0, 2);
    chk("t6_idle_cs", bus.cs_n, 1);

    // reset mid-XFER
    issue_cmd(4'd3, 1'b0);
    feed_byte(8'h5A, 1'b1);
    rst = 1'b0;
    #1;
    chk("t7_async_cs", bus.cs_n, 1);
    chk("t7_rst_rx_valid", bus.rx_valid, 0);
    exp_q.delete();
    exp_done = 0;
    repeat (3) step();
    rst = 1'b1;
    r0 = n_rx; d0 = n_done;
    repeat (12) step();
    chk("t7_cmd_ready", bus.cmd_ready, 1);
    chk("t7_no_rx", n_rx - r0, 0);
    chk("t7_no_done", n_done - d0, 0);
    chk("t7_cs_high", bus.cs_n, 1);

    chk("queue_empty", exp_q.size(), 0);
    chk("done_outstanding", exp_done, 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
